// File: rtl/aes_128to4.sv
// aes_128to4 -- output-side serializer for the AES core.
// Captures a 128-bit result word on a single-cycle done pulse and streams it
// out as 32 four-bit nibbles over a valid/ready handshake, then pulses sent.
// Optional feature macro: AES_128TO4_OVERRUN_EN (sticky dropped-done flag).
// Every output is a flop; nothing combinational reaches a port from ready/done.

module aes_128to4 #(
    parameter bit MSB_FIRST = 1'b1   // 1: [127:124] leaves first, 0: [3:0] first
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [127:0] text_out,
    input  logic         ready,
    output logic [3:0]   block_out,
    output logic         valid,
    output logic         last,
    output logic         busy,
    output logic         sent,
    output logic         overrun
);

    // One-hot encoding; anything else falls through the default arm to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SEND = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t       state;
    logic [127:0] shreg;
    logic [4:0]   count;
    logic [127:0] shreg_shifted;
    logic         accept;

    // Move the word 4 bits toward the output end, zero-filling behind it.
    function automatic logic [127:0] shift4(input logic [127:0] v);
        if (MSB_FIRST)
            return {v[123:0], 4'h0};
        else
            return {4'h0, v[127:4]};
    endfunction

    // Nibble sitting at the output end of a word.
    function automatic logic [3:0] head(input logic [127:0] v);
        if (MSB_FIRST)
            return v[127:124];
        else
            return v[3:0];
    endfunction

    // valid is the registered output, so acceptance depends only on flops and ready.
    assign accept        = valid & ready;
    assign shreg_shifted = shift4(shreg);

    // Main FSM: state, shift register, beat counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            block_out <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            sent      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sent <= 1'b0;
                    last <= 1'b0;
                    if (done) begin
                        // text_out is only sampled here; the first nibble is
                        // presented directly so valid rises on the next cycle.
                        shreg     <= text_out;
                        count     <= '0;
                        block_out <= head(text_out);
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                SEND: begin
                    // With ready low everything simply holds.
                    if (accept) begin
                        shreg     <= shreg_shifted;
                        count     <= count + 5'd1;
                        block_out <= head(shreg_shifted);
                        if (count == 5'd31) begin
                            // Final nibble taken: the shifted word is all zero,
                            // so block_out returns to 0 as well.
                            valid <= 1'b0;
                            last  <= 1'b0;
                            sent  <= 1'b1;
                            state <= DONE;
                        end else begin
                            last <= (count == 5'd30);
                        end
                    end
                end

                DONE: begin
                    // sent is a single-cycle pulse; busy drops one cycle later.
                    sent  <= 1'b0;
                    valid <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    valid <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    sent  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AES_128TO4_OVERRUN_EN
    // Sticky flag: a done arriving while a word is in flight was dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (done && (state != IDLE))
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_aes_128to4.sv
// Self-checking bench for aes_128to4. Two instances (MSB_FIRST=1 and 0) share
// the stimulus; the reference model picks nibbles straight out of the word.
module tb_aes_128to4;

    logic         clk = 1'b0;
    logic         rst;
    logic         done;
    logic         ready;
    logic [127:0] text_out;

    logic [3:0] m_bo, l_bo;
    logic       m_valid, m_last, m_busy, m_sent, m_ov;
    logic       l_valid, l_last, l_busy, l_sent, l_ov;

    int   checks = 0;
    int   fails  = 0;
    logic ov_exp = 1'b0;

`ifdef AES_128TO4_OVERRUN_EN
    localparam logic OV_ON = 1'b1;
`else
    localparam logic OV_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    aes_128to4 #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .done(done), .text_out(text_out), .ready(ready),
        .block_out(m_bo), .valid(m_valid), .last(m_last), .busy(m_busy),
        .sent(m_sent), .overrun(m_ov)
    );

    aes_128to4 #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .done(done), .text_out(text_out), .ready(ready),
        .block_out(l_bo), .valid(l_valid), .last(l_last), .busy(l_busy),
        .sent(l_sent), .overrun(l_ov)
    );

    // Observed output bundles: {overrun, valid, last, busy, sent, block_out}
    wire [8:0] om = {m_ov, m_valid, m_last, m_busy, m_sent, m_bo};
    wire [8:0] ol = {l_ov, l_valid, l_last, l_busy, l_sent, l_bo};

    // Model: nibble k of the transmit order for a given word and bit order.
    function automatic logic [3:0] nib(input logic [127:0] w, input bit msb, input int k);
        int sh;
        sh = msb ? (124 - 4 * k) : (4 * k);
        return 4'((w >> sh) & 128'hF);
    endfunction

    function automatic logic [8:0] ev(input logic v, input logic l, input logic b,
                                      input logic s, input logic [3:0] n);
        return {ov_exp, v, l, b, s, n};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sample point: 1 time unit after the rising edge; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst = 1'b1; done = 1'b0; ready = 1'b0; text_out = '0;
        step(); step();
        e = ev(0, 0, 0, 0, 4'h0);
        checks++; if (om !== e) begin fails++; $display("FAIL reset_msb got %h want %h", om, e); end
        checks++; if (ol !== e) begin fails++; $display("FAIL reset_lsb got %h want %h", ol, e); end
        rst = 1'b0;
        step();
        checks++; if (om !== e) begin fails++; $display("FAIL reset_release_msb got %h want %h", om, e); end
        checks++; if (ol !== e) begin fails++; $display("FAIL reset_release_lsb got %h want %h", ol, e); end
    endtask

    task automatic test_basic();
        logic [127:0] w;
        logic [8:0]   em, el;
        w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ready = 1'b1; text_out = w; done = 1'b1;
        step();
        done = 1'b0; text_out = rnd128();   // must not leak into the word
        for (int k = 0; k < 32; k++) begin
            em = ev(1, k == 31, 1, 0, nib(w, 1, k));
            el = ev(1, k == 31, 1, 0, nib(w, 0, k));
            checks++; if (om !== em) begin fails++; $display("FAIL basic_msb beat %0d got %h want %h", k, om, em); end
            checks++; if (ol !== el) begin fails++; $display("FAIL basic_lsb beat %0d got %h want %h", k, ol, el); end
            step();
        end
        em = ev(0, 0, 1, 1, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL basic_sent_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL basic_sent_lsb got %h want %h", ol, em); end
        step();
        em = ev(0, 0, 0, 0, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL basic_idle_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL basic_idle_lsb got %h want %h", ol, em); end
    endtask

    // done issued in the very cycle busy first reads 0, three words in a row.
    task automatic test_back_to_back();
        logic [127:0] w;
        logic [8:0]   em, el;
        ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            w = rnd128();
            text_out = w; done = 1'b1;
            step();
            done = 1'b0;
            for (int k = 0; k < 32; k++) begin
                em = ev(1, k == 31, 1, 0, nib(w, 1, k));
                el = ev(1, k == 31, 1, 0, nib(w, 0, k));
                checks++; if (om !== em) begin fails++; $display("FAIL b2b_msb word %0d beat %0d got %h want %h", r, k, om, em); end
                checks++; if (ol !== el) begin fails++; $display("FAIL b2b_lsb word %0d beat %0d got %h want %h", r, k, ol, el); end
                step();
            end
            em = ev(0, 0, 1, 1, 4'h0);
            checks++; if (om !== em) begin fails++; $display("FAIL b2b_sent_msb word %0d got %h want %h", r, om, em); end
            checks++; if (ol !== em) begin fails++; $display("FAIL b2b_sent_lsb word %0d got %h want %h", r, ol, em); end
            step();
            em = ev(0, 0, 0, 0, 4'h0);
            checks++; if (om !== em) begin fails++; $display("FAIL b2b_idle_msb word %0d got %h want %h", r, om, em); end
            checks++; if (ol !== em) begin fails++; $display("FAIL b2b_idle_lsb word %0d got %h want %h", r, ol, em); end
        end
    endtask

    // Random ready: outputs must hold during stalls, exactly 32 acceptances.
    task automatic test_stall();
        logic [127:0] w;
        logic [8:0]   em, el;
        int           k, cyc;
        w = rnd128();
        ready = 1'b0; text_out = w; done = 1'b1;
        step();
        done = 1'b0;
        k = 0; cyc = 0;
        while (k < 32 && cyc < 2000) begin
            em = ev(1, k == 31, 1, 0, nib(w, 1, k));
            el = ev(1, k == 31, 1, 0, nib(w, 0, k));
            checks++; if (om !== em) begin fails++; $display("FAIL stall_msb beat %0d cyc %0d got %h want %h", k, cyc, om, em); end
            checks++; if (ol !== el) begin fails++; $display("FAIL stall_lsb beat %0d cyc %0d got %h want %h", k, cyc, ol, el); end
            ready = 1'($urandom_range(0, 1));
            step();
            if (ready) k++;
            cyc++;
        end
        checks++; if (k != 32) begin fails++; $display("FAIL stall_budget accepted %0d want 32", k); end
        ready = 1'b1;
        em = ev(0, 0, 1, 1, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL stall_sent_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL stall_sent_lsb got %h want %h", ol, em); end
        step();
        em = ev(0, 0, 0, 0, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL stall_idle_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL stall_idle_lsb got %h want %h", ol, em); end
    endtask

    // Extra done mid-word and in the sent cycle: word intact, flag per build.
    task automatic test_overrun();
        logic [127:0] w, w2;
        logic [8:0]   em, el;
        w = rnd128(); w2 = ~w;
        ready = 1'b1; text_out = w; done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            em = ev(1, k == 31, 1, 0, nib(w, 1, k));
            el = ev(1, k == 31, 1, 0, nib(w, 0, k));
            checks++; if (om !== em) begin fails++; $display("FAIL overrun_msb beat %0d got %h want %h", k, om, em); end
            checks++; if (ol !== el) begin fails++; $display("FAIL overrun_lsb beat %0d got %h want %h", k, ol, el); end
            if (k == 10) begin done = 1'b1; text_out = w2; end
            else done = 1'b0;
            step();
            if (k == 10) ov_exp = OV_ON;
        end
        em = ev(0, 0, 1, 1, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL overrun_sent_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL overrun_sent_lsb got %h want %h", ol, em); end
        done = 1'b1; text_out = w2;          // ignored: not yet IDLE
        step();
        done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            em = ev(0, 0, 0, 0, 4'h0);
            checks++; if (om !== em) begin fails++; $display("FAIL overrun_idle_msb %0d got %h want %h", i, om, em); end
            checks++; if (ol !== em) begin fails++; $display("FAIL overrun_idle_lsb %0d got %h want %h", i, ol, em); end
            step();
        end
    endtask

    // Reset at beat 20 abandons the word; a fresh word then streams cleanly.
    task automatic test_midreset();
        logic [127:0] w;
        logic [8:0]   em, el;
        w = rnd128();
        ready = 1'b1; text_out = w; done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 20; k++) step();
        em = ev(1, 0, 1, 0, nib(w, 1, 20));
        el = ev(1, 0, 1, 0, nib(w, 0, 20));
        checks++; if (om !== em) begin fails++; $display("FAIL midrst_pre_msb got %h want %h", om, em); end
        checks++; if (ol !== el) begin fails++; $display("FAIL midrst_pre_lsb got %h want %h", ol, el); end
        rst = 1'b1;
        #1;
        ov_exp = 1'b0;
        em = ev(0, 0, 0, 0, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL midrst_async_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL midrst_async_lsb got %h want %h", ol, em); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (om !== em) begin fails++; $display("FAIL midrst_quiet_msb %0d got %h want %h", i, om, em); end
            checks++; if (ol !== em) begin fails++; $display("FAIL midrst_quiet_lsb %0d got %h want %h", i, ol, em); end
        end
        w = rnd128();
        text_out = w; done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            em = ev(1, k == 31, 1, 0, nib(w, 1, k));
            el = ev(1, k == 31, 1, 0, nib(w, 0, k));
            checks++; if (om !== em) begin fails++; $display("FAIL midrst_new_msb beat %0d got %h want %h", k, om, em); end
            checks++; if (ol !== el) begin fails++; $display("FAIL midrst_new_lsb beat %0d got %h want %h", k, ol, el); end
            step();
        end
        em = ev(0, 0, 1, 1, 4'h0);
        checks++; if (om !== em) begin fails++; $display("FAIL midrst_sent_msb got %h want %h", om, em); end
        checks++; if (ol !== em) begin fails++; $display("FAIL midrst_sent_lsb got %h want %h", ol, em); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_128to4.md
# aes_128to4

Output-side serializer for the AES core. Captures a 128-bit result word on a single-cycle `done` pulse and streams it out as 32 four-bit nibbles over a valid/ready handshake, then pulses `sent`. It sits between the AES core's `text_out` and the narrow 4-bit pad interface. It is the transmit counterpart of the 4-bit-to-128-bit input loader.

## Interface
- `MSB_FIRST`, default 1: 1 sends `text_out[127:124]` first and `[3:0]` last; 0 sends `[3:0]` first and `[127:124]` last.

- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `done` in 1: single-cycle pulse; `text_out` is valid in the same cycle.
- `text_out` in 128: AES result word.
- `ready` in 1: downstream accepts the current nibble when `valid & ready`.
- `block_out` out 4: current nibble.
- `valid` out 1: `block_out` holds a nibble.
- `last` out 1: the current nibble is the 32nd of the word.
- `busy` out 1: state is not IDLE.
- `sent` out 1: one-cycle pulse after the final nibble is accepted.
- `overrun` out 1: sticky; a `done` pulse was dropped (see Configuration).

## Operation
- One-hot FSM with three states: IDLE=3'b001, SEND=3'b010, DONE=3'b100. Any illegal encoding returns to IDLE on the next edge.
- **IDLE**
  - On `done`: load a 128-bit shift register from `text_out`, clear the 5-bit beat counter, go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - `valid=1`.
  - `block_out` is the shift register's top nibble (`[127:124]`) when `MSB_FIRST=1`, or its bottom nibble (`[3:0]`) when `MSB_FIRST=0`.
  - On `valid & ready`: shift the register by 4 toward the output end, zero-filling the vacated end, and increment the counter.
  - `last = (count == 5'd31)`.
  - Acceptance with `count == 31` moves to DONE. The counter wraps to 0.
  - When `ready=0`, `block_out`, `valid`, `last` and `count` hold their values. Stalls of any length are allowed.
- **DONE**
  - `sent=1` and `valid=0` for exactly one cycle, then go to IDLE.
- `done` in SEND or DONE is ignored. The in-flight word is never corrupted.
- `text_out` is sampled only in the cycle where `done=1` and the state is IDLE.
- Every output is registered. No combinational path runs from `ready` or `done` to any output.

## Timing
- Reset values: state=IDLE, shift register=0, count=0, `block_out`=0, `valid`=0, `last`=0, `busy`=0, `sent`=0, `overrun`=0.
- Reset asserted mid-word abandons the word immediately. No `sent` is produced.
- Latency:
  - `done` at edge N puts the first nibble on `block_out` with `valid=1` after edge N+1.
  - With `ready` held high, 32 consecutive beats follow, `last` on the 32nd.
  - `sent` is high in the cycle after the last acceptance.
  - `busy` drops one cycle after `sent`.
- Minimum done-to-done spacing is 34 cycles with `ready` held high. A `done` in the cycle `busy` first reads 0 is accepted.
- `busy=1` in SEND and DONE.

## Configuration
- Macro: `AES_128TO4_OVERRUN_EN`.
- **Defined**
  - A `done` pulse while state≠IDLE sets `overrun` on the following edge.
  - `overrun` holds until `rst`.
  - Dropped words are still discarded.
- **Not defined**
  - `overrun` is tied to 0. No flag logic is synthesized.
  - The port is present in both builds.

## Test plan
- Reset, then `done` with `text_out=128'h00112233_44556677_8899AABB_CCDDEEFF`, `ready=1`, `MSB_FIRST=1` -> nibbles 0,0,1,1,…,F,F on 32 consecutive cycles starting one cycle after `done`. `last` is high only on the final F. `sent` pulses in the next cycle.
- Same word with `MSB_FIRST=0` -> first nibble F, last nibble 0, 32 beats.
- `ready` toggled with a pseudo-random pattern (~50% duty) -> the sequence matches the first test exactly. `block_out` is stable while `valid & !ready`. Exactly 32 acceptances occur.
- Second `done` at beat 10 of a word -> the first word completes unaltered. With the macro defined, `overrun=1` from the next cycle until reset. Without it, `overrun` stays 0.
- Assert `rst` at beat 20 -> all outputs go to 0 asynchronously and no `sent` appears. A new `done` after release streams its new word correctly from nibble 1.
- Back-to-back: `done` in the first cycle after `busy` falls -> accepted with no overrun. The first nibble appears one cycle later.
